seg7_scan_mux: RTL and testbench

Parametrised multiplexed driver for an N-digit common-anode 7-segment display. Holds a shadow copy of N packed BCD digits with per-digit decimal point and blank flags, and time-multiplexes them onto one shared active-low segment bus and N active-low digit enables. Adds a '-' glyph, optional leading-zero suppression and inter-digit dead time against ghosting. Sits between the counter/datapath logic and the board's display pins.

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_glyph_rom.sv | 12 +
 rtl/seg7_scan_mux.sv | 106 ++++++++++
 tb/tb_seg7_scan_mux.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared glyph constants and code-to-segment lookup for the 7-segment scan driver.
// Segment order is {DP,G,F,E,D,C,B,A}, active-low.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;

  localparam logic [3:0] CODE_MINUS = 4'hA;
  // Any code above CODE_MINUS renders dark; this one is used for suppressed digits.
  localparam logic [3:0] CODE_BLANK = 4'hF;

  function automatic logic [7:0] seg7_glyph(input logic [3:0] code, input logic dp);
    logic [7:0] g;
    case (code)
      4'h0:       g = SEG_0;
      4'h1:       g = SEG_1;
      4'h2:       g = SEG_2;
      4'h3:       g = SEG_3;
      4'h4:       g = SEG_4;
      4'h5:       g = SEG_5;
      4'h6:       g = SEG_6;
      4'h7:       g = SEG_7;
      4'h8:       g = SEG_8;
      4'h9:       g = SEG_9;
      CODE_MINUS: g = SEG_MINUS;
      default:    g = SEG_BLANK;
    endcase
    if (dp) g[7] = 1'b0;
    return g;
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational code + decimal point to active-low segment pattern.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = seg7_glyph(code, dp);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit common-anode display driver with shadowed digit data,
// leading-zero suppression and a dead phase at the start of every digit slot.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_en,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEAD_CNT = DW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DW-1:0]         div;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   bcd_sh;
  logic [DIGITS-1:0]     dp_sh;
  logic [DIGITS-1:0]     blank_sh;

  logic [DIGITS-1:0]     supp;
  logic                  zero_run;
  logic                  dead;
  logic [3:0]            cur_code;
  logic [3:0]            rom_code;
  logic [7:0]            rom_seg;
  logic [7:0]            seg_nxt;
  logic [DIGITS-1:0]     an_nxt;

  // Shadows are only written on load, so a digit can never show half of an update.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_sh   <= '0;
      dp_sh    <= '0;
      blank_sh <= '1;
    end else if (load) begin
      bcd_sh   <= bcd_in;
      dp_sh    <= dp_in;
      blank_sh <= blank_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Walk down from the most significant digit; a digit is suppressed while every
  // digit at or above it is zero. Digit 0 is excluded so a value of 0 still shows.
  always_comb begin
    supp     = '0;
    zero_run = lz_en;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (bcd_sh[4*i +: 4] == 4'h0);
      supp[i]  = zero_run;
    end
  end

  always_comb begin
    cur_code = bcd_sh[{idx, 2'b00} +: 4];
    rom_code = supp[idx] ? CODE_BLANK : cur_code;
  end

  seg7_glyph_rom u_glyph (
    .code (rom_code),
    .dp   (dp_sh[idx]),
    .seg  (rom_seg)
  );

  always_comb begin
    dead   = (div < DEAD_CNT);
    an_nxt = '1;
    if (!dead) an_nxt[idx] = 1'b0;
    seg_nxt = (dead || blank_sh[idx]) ? SEG_BLANK : rom_seg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed and randomized check of seg7_scan_mux against a frame-position reference model.
module tb_seg7_scan_mux;

  localparam int D  = 4;
  localparam int SD = 8;
  localparam int DD = 2;
  localparam int FRAME = D * SD;

  logic           clk;
  logic           rst;
  logic           load;
  logic [4*D-1:0] bcd_in;
  logic [D-1:0]   dp_in;
  logic [D-1:0]   blank_in;
  logic           lz_en;
  logic [7:0]     seg;
  logic [D-1:0]   an;

  seg7_scan_mux #(.DIGITS(D), .SCAN_DIV(SD), .DEAD(DD)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .bcd_in   (bcd_in),
    .dp_in    (dp_in),
    .blank_in (blank_in),
    .lz_en    (lz_en),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cycles since reset plus a plain copy of the shadow data.
  int         cnt = 0;
  logic [3:0] m_bcd [D];
  logic       m_dp  [D];
  logic       m_blk [D];
  int         cur_slot;
  int         cur_offs;
  logic [7:0] glyph_tab [16];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_seg(input int slot);
    logic [7:0] g;
    bit         allzero;
    allzero = 1'b1;
    for (int j = slot; j < D; j++) if (m_bcd[j] != 4'h0) allzero = 1'b0;
    if (m_blk[slot]) return 8'hFF;
    g = glyph_tab[m_bcd[slot]];
    if (lz_en && slot >= 1 && allzero) g = 8'hFF;
    if (m_dp[slot]) g = g & 8'h7F;
    return g;
  endfunction

  task automatic tick();
    logic [7:0] es;
    logic [3:0] ea;
    cur_slot = (cnt / SD) % D;
    cur_offs = cnt % SD;
    if (rst || cur_offs < DD) begin
      ea = 4'hF;
      es = 8'hFF;
    end else begin
      ea = ~(4'b0001 << cur_slot);
      es = model_seg(cur_slot);
    end
    if (rst) begin
      cnt = 0;
      for (int j = 0; j < D; j++) begin
        m_bcd[j] = 4'h0; m_dp[j] = 1'b0; m_blk[j] = 1'b1;
      end
    end else begin
      cnt++;
      if (load) begin
        for (int j = 0; j < D; j++) begin
          m_bcd[j] = bcd_in[4*j +: 4]; m_dp[j] = dp_in[j]; m_blk[j] = blank_in[j];
        end
      end
    end
    @(posedge clk);
    #1;
    chk("an_model", {4'h0, an}, {4'h0, ea});
    chk("seg_model", seg, es);
    vectors++;
    assert ($countones(~an) <= 1)
    else begin
      miscompares++;
      $error("FAIL an_onehot observed=%b expected=at most one low bit", an);
    end
  endtask

  // One frame with load idle; lit slots must show the given glyphs, dead phases dark.
  task automatic check_frame(input string tag, input logic [7:0] g0, input logic [7:0] g1,
                             input logic [7:0] g2, input logic [7:0] g3);
    logic [7:0] exp_g [D];
    exp_g[0] = g0; exp_g[1] = g1; exp_g[2] = g2; exp_g[3] = g3;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if (cur_offs >= DD) begin
        chk({tag, "_an"}, {4'h0, an}, {4'h0, ~(4'b0001 << cur_slot)});
        chk({tag, "_seg"}, seg, exp_g[cur_slot]);
      end else begin
        chk({tag, "_dead_an"}, {4'h0, an}, 8'h0F);
        chk({tag, "_dead_seg"}, seg, 8'hFF);
      end
    end
  endtask

  task automatic advance_to(input int slot, input int offs);
    int k;
    k = 0;
    while (cnt % FRAME != slot * SD + offs && k < 2 * FRAME) begin
      tick();
      k++;
    end
    vectors++;
    assert (cnt % FRAME == slot * SD + offs)
    else begin
      miscompares++;
      $error("FAIL advance_timeout observed=%0d expected=%0d", cnt % FRAME, slot * SD + offs);
    end
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d, input logic [3:0] bl);
    bcd_in = b; dp_in = d; blank_in = bl; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    glyph_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int j = 0; j < D; j++) begin
      m_bcd[j] = 4'h0; m_dp[j] = 1'b0; m_blk[j] = 1'b1;
    end
    rst = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0; blank_in = '0; lz_en = 1'b0;
    tick();
    chk("reset_an", {4'h0, an}, 8'h0F);
    chk("reset_seg", seg, 8'hFF);
    rst = 1'b0;

    // Dark display after reset for a whole frame.
    for (int k = 0; k < FRAME; k++) begin
      tick();
      chk("s1_dark_seg", seg, 8'hFF);
    end

    do_load(16'h1234, 4'b0000, 4'b0000);
    check_frame("s2_1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    lz_en = 1'b1;
    do_load(16'h0070, 4'b0000, 4'b0000);
    check_frame("s3_lz_on", 8'hC0, 8'hF8, 8'hFF, 8'hFF);
    lz_en = 1'b0;
    check_frame("s3_lz_off", 8'hC0, 8'hF8, 8'hC0, 8'hC0);

    // Suppressed digits keep their decimal point.
    lz_en = 1'b1;
    do_load(16'h0000, 4'b1100, 4'b0000);
    check_frame("s3_lz_dp", 8'hC0, 8'hFF, 8'h7F, 8'h7F);
    lz_en = 1'b0;

    do_load(16'hA5F0, 4'b0100, 4'b0001);
    check_frame("s4_codes", 8'hFF, 8'hFF, 8'h12, 8'hBF);

    // Mid-slot load: lit digit changes glyph immediately, no dead phase.
    advance_to(2, 4);
    do_load(16'h9876, 4'b0000, 4'b0000);
    tick();
    chk("s5_mid_an", {4'h0, an}, 8'h0B);
    chk("s5_mid_seg", seg, 8'h80);

    // Load coincident with the slot wrap: next slot shows the new data.
    advance_to(2, SD - 1);
    do_load(16'h4321, 4'b1000, 4'b0000);
    for (int k = 0; k < DD; k++) tick();
    tick();
    chk("s5_wrap_an", {4'h0, an}, 8'h07);
    chk("s5_wrap_seg", seg, 8'h19);

    // Reset mid-slot of digit 3, with load asserted to confirm reset priority.
    advance_to(3, 4);
    rst = 1'b1;
    bcd_in = 16'h5555; dp_in = '0; blank_in = '0; load = 1'b1;
    tick();
    load = 1'b0;
    chk("s6_rst_an", {4'h0, an}, 8'h0F);
    chk("s6_rst_seg", seg, 8'hFF);
    rst = 1'b0;
    do_load(16'h8888, 4'b0000, 4'b0000);
    for (int k = 1; k < DD; k++) tick();
    tick();
    chk("s6_restart_an", {4'h0, an}, 8'h0E);
    chk("s6_restart_seg", seg, 8'h80);

    // Randomized loads, lz_en toggles and occasional resets against the model.
    for (int k = 0; k < 2000; k++) begin
      load = ($urandom_range(0, 5) == 0);
      bcd_in = 16'($urandom);
      if ($urandom_range(0, 2) == 0) bcd_in[15:8] = 8'h00;
      dp_in = 4'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 19) == 0) lz_en = ~lz_en;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
